// File: rtl/galaga_duel_ctrl.sv
// Two-player duel controller: lanes, fire cooldown, armour, lives and IDLE/PLAY/OVER flow.
// Optional build macro GALAGA_WRAP_EN makes lane movement wrap instead of saturating.
module galaga_duel_ctrl #(
  parameter int LANES    = 3,
  parameter int LANE_W   = 2,
  parameter int LIVES    = 3,
  parameter int LIFE_W   = 2,
  parameter int ARMOR    = 1,
  parameter int ARM_W    = 1,
  parameter int COOLDOWN = 4,
  parameter int CD_W     = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              P1_LEFT,
  input  logic              P1_RIGHT,
  input  logic              P1_FIRE,
  input  logic              P2_LEFT,
  input  logic              P2_RIGHT,
  input  logic              P2_FIRE,
  output logic [LANE_W-1:0] P1_POS,
  output logic [LANE_W-1:0] P2_POS,
  output logic [LIFE_W-1:0] P1_LIVES,
  output logic [LIFE_W-1:0] P2_LIVES,
  output logic [ARM_W-1:0]  P1_ARMOR,
  output logic [ARM_W-1:0]  P2_ARMOR,
  output logic              ALIGN,
  output logic              HIT1,
  output logic              HIT2,
  output logic              DONE,
  output logic [1:0]        WINNER
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [LANE_W-1:0] POS_INIT  = LANE_W'(LANES / 2);
  localparam logic [LANE_W-1:0] POS_MAX   = LANE_W'(LANES - 1);
  localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIVES);
  localparam logic [ARM_W-1:0]  ARM_INIT  = ARM_W'(ARMOR);
  localparam logic [CD_W-1:0]   CD_INIT   = CD_W'(COOLDOWN);

  logic [1:0]        state, state_d;
  logic [LANE_W-1:0] p1_pos, p1_pos_d, p2_pos, p2_pos_d;
  logic [LIFE_W-1:0] p1_lives, p1_lives_d, p2_lives, p2_lives_d;
  logic [ARM_W-1:0]  p1_armor, p1_armor_d, p2_armor, p2_armor_d;
  logic [CD_W-1:0]   p1_cd, p1_cd_d, p2_cd, p2_cd_d;
  logic              hit1_q, hit1_d, hit2_q, hit2_d;
  logic [1:0]        winner_q, winner_d;
  logic              fire1, fire2;
  logic              align;

  function automatic logic [LANE_W-1:0] step_pos(input logic [LANE_W-1:0] pos,
                                                 input logic left, input logic right);
    logic [LANE_W-1:0] nxt;
    nxt = pos;
    if (left && !right) begin
      if (pos != '0)
        nxt = pos - LANE_W'(1);
`ifdef GALAGA_WRAP_EN
      else
        nxt = POS_MAX;
`endif
    end else if (right && !left) begin
      if (pos != POS_MAX)
        nxt = pos + LANE_W'(1);
`ifdef GALAGA_WRAP_EN
      else
        nxt = '0;
`endif
    end
    return nxt;
  endfunction

  assign align = (p1_pos == p2_pos);

  always_comb begin
    state_d    = state;
    p1_pos_d   = p1_pos;
    p2_pos_d   = p2_pos;
    p1_lives_d = p1_lives;
    p2_lives_d = p2_lives;
    p1_armor_d = p1_armor;
    p2_armor_d = p2_armor;
    p1_cd_d    = p1_cd;
    p2_cd_d    = p2_cd;
    hit1_d     = 1'b0;
    hit2_d     = 1'b0;
    winner_d   = winner_q;
    fire1      = 1'b0;
    fire2      = 1'b0;
    case (state)
      S_PLAY: begin
        fire1    = P1_FIRE && (p1_cd == '0);
        fire2    = P2_FIRE && (p2_cd == '0);
        p1_pos_d = step_pos(p1_pos, P1_LEFT, P1_RIGHT);
        p2_pos_d = step_pos(p2_pos, P2_LEFT, P2_RIGHT);
        p1_cd_d  = fire1 ? CD_INIT : ((p1_cd != '0) ? p1_cd - CD_W'(1) : p1_cd);
        p2_cd_d  = fire2 ? CD_INIT : ((p2_cd != '0) ? p2_cd - CD_W'(1) : p2_cd);
        // Hits are judged on pre-edge positions; armour absorbs before lives.
        hit1_d   = fire1 && align;
        hit2_d   = fire2 && align;
        if (hit1_d) begin
          if (p2_armor != '0)
            p2_armor_d = p2_armor - ARM_W'(1);
          else if (p2_lives != '0)
            p2_lives_d = p2_lives - LIFE_W'(1);
        end
        if (hit2_d) begin
          if (p1_armor != '0)
            p1_armor_d = p1_armor - ARM_W'(1);
          else if (p1_lives != '0)
            p1_lives_d = p1_lives - LIFE_W'(1);
        end
        if ((p1_lives_d == '0) || (p2_lives_d == '0)) begin
          state_d  = S_OVER;
          winner_d = {p1_lives_d == '0, p2_lives_d == '0};
        end
      end
      default: begin
        if (START) begin
          state_d    = S_PLAY;
          p1_pos_d   = POS_INIT;
          p2_pos_d   = POS_INIT;
          p1_lives_d = LIFE_INIT;
          p2_lives_d = LIFE_INIT;
          p1_armor_d = ARM_INIT;
          p2_armor_d = ARM_INIT;
          p1_cd_d    = '0;
          p2_cd_d    = '0;
          winner_d   = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      p1_pos   <= POS_INIT;
      p2_pos   <= POS_INIT;
      p1_lives <= LIFE_INIT;
      p2_lives <= LIFE_INIT;
      p1_armor <= ARM_INIT;
      p2_armor <= ARM_INIT;
      p1_cd    <= '0;
      p2_cd    <= '0;
      hit1_q   <= 1'b0;
      hit2_q   <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      state    <= state_d;
      p1_pos   <= p1_pos_d;
      p2_pos   <= p2_pos_d;
      p1_lives <= p1_lives_d;
      p2_lives <= p2_lives_d;
      p1_armor <= p1_armor_d;
      p2_armor <= p2_armor_d;
      p1_cd    <= p1_cd_d;
      p2_cd    <= p2_cd_d;
      hit1_q   <= hit1_d;
      hit2_q   <= hit2_d;
      winner_q <= winner_d;
    end
  end

  assign P1_POS   = p1_pos;
  assign P2_POS   = p2_pos;
  assign P1_LIVES = p1_lives;
  assign P2_LIVES = p2_lives;
  assign P1_ARMOR = p1_armor;
  assign P2_ARMOR = p2_armor;
  assign ALIGN    = align;
  assign HIT1     = hit1_q;
  assign HIT2     = hit2_q;
  assign DONE     = (state == S_OVER);
  assign WINNER   = winner_q;

endmodule
